// File: rtl/output_pingpong_buffer_if.sv
// output_pingpong_buffer_if
//   Port bundle for output_pingpong_buffer.
//   Write side : wr_en, wr_row, wr_mask, wr_data, wr_commit -> wr_ready
//                (wr_acc only when OUTBUF_ACCUM_EN is defined)
//   Drain side : out_valid, out_data, out_last <- out_ready
//   Status     : bank_full (one FULL bit per bank)
//   master = producer/consumer side, slave = buffer side.
interface output_pingpong_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int ROW_W      = 2
);
  logic                         wr_en;
  logic [ROW_W-1:0]             wr_row;
  logic [NUM_CH-1:0]            wr_mask;
  logic [NUM_CH*DATA_WIDTH-1:0] wr_data;
`ifdef OUTBUF_ACCUM_EN
  logic                         wr_acc;
`endif
  logic                         wr_commit;
  logic                         wr_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_data;
  logic                         out_last;
  logic [1:0]                   bank_full;

  modport master (
    output wr_en, wr_row, wr_mask, wr_data,
`ifdef OUTBUF_ACCUM_EN
    output wr_acc,
`endif
    output wr_commit, out_ready,
    input  wr_ready, out_valid, out_data, out_last, bank_full
  );

  modport slave (
    input  wr_en, wr_row, wr_mask, wr_data,
`ifdef OUTBUF_ACCUM_EN
    input  wr_acc,
`endif
    input  wr_commit, out_ready,
    output wr_ready, out_valid, out_data, out_last, bank_full
  );
endinterface

// File: rtl/output_pingpong_buffer.sv
// output_pingpong_buffer
//   Two-bank result buffer. The fill side writes rows of NUM_CH lanes into the
//   current fill bank and commits it; the drain side streams a committed bank
//   out one word per cycle (row-major) over a valid/ready port while the other
//   bank is being filled.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset (control state only, not storage)
//     bus  - output_pingpong_buffer_if.slave (write, drain and status signals)
//   Build option:
//     OUTBUF_ACCUM_EN - adds wr_acc: accepted writes with wr_acc=1 store the
//                       signed saturating sum of old contents and wr_data.
module output_pingpong_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int ROWS       = 4,
  parameter int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output_pingpong_buffer_if.slave bus
);
  localparam int NWORDS = ROWS * NUM_CH;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LANE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic {IDLE, STREAM} drain_state_t;

  drain_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] mem [2][ROWS][NUM_CH];
  logic [DATA_WIDTH-1:0] wr_word [NUM_CH];

  logic [1:0]            full_q;
  logic                  wbank_q;
  logic                  rbank_q;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  load_word;
  logic                  drain_done;
  logic                  fill_ok;
  logic                  wr_accept;
  logic                  commit_accept;
  logic [ROW_W-1:0]      rd_row;
  logic [LANE_W-1:0]     rd_lane;

`ifdef OUTBUF_ACCUM_EN
  // Sign-extend by one bit; overflow shows up as the two top bits differing.
  function automatic logic [DATA_WIDTH-1:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
      return s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return s[DATA_WIDTH-1:0];
  endfunction
`endif

  assign fill_ok       = ~full_q[wbank_q];
  assign wr_accept     = bus.wr_en && fill_ok && (32'(bus.wr_row) < ROWS);
  assign commit_accept = bus.wr_commit && fill_ok;

  // Per-lane value to store on an accepted write.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef OUTBUF_ACCUM_EN
      wr_word[LANE_W'(i)] = bus.wr_acc
        ? sat_add(mem[wbank_q][bus.wr_row][LANE_W'(i)], bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH])
        : bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
`else
      wr_word[LANE_W'(i)] = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
`endif
    end
  end

  // Storage has no reset. A write paired with a commit lands in the bank
  // being committed because both use the pre-edge wbank_q.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (bus.wr_mask[LANE_W'(i)])
          mem[wbank_q][bus.wr_row][LANE_W'(i)] <= wr_word[LANE_W'(i)];
      end
    end
  end

  // Drain FSM: next word index is computed here and the word is fetched into
  // out_data at the same edge, so a handshake every cycle gives full rate.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    load_word   = 1'b0;
    drain_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          state_d     = STREAM;
          idx_d       = '0;
          load_word   = 1'b1;
          out_valid_d = 1'b1;
          out_last_d  = (LAST_IDX == '0);
        end
      end
      STREAM: begin
        // out_valid is always high in STREAM, so out_ready alone is the handshake.
        if (bus.out_ready) begin
          if (out_last_q) begin
            drain_done  = 1'b1;
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            idx_d      = idx_q + 1'b1;
            load_word  = 1'b1;
            out_last_d = (idx_d == LAST_IDX);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_row  = ROW_W'(idx_d / NUM_CH);
    rd_lane = LANE_W'(idx_d % NUM_CH);
  end

  // Commit and final-drain handshake always address different banks
  // (one requires FREE, the other FULL), so both updates may land together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      full_q      <= '0;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      if (load_word)
        out_data_q <= mem[rbank_q][rd_row][rd_lane];
      if (commit_accept) begin
        full_q[wbank_q] <= 1'b1;
        wbank_q         <= ~wbank_q;
      end
      if (drain_done) begin
        full_q[rbank_q] <= 1'b0;
        rbank_q         <= ~rbank_q;
      end
    end
  end

  assign bus.wr_ready  = fill_ok;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.bank_full = full_q;
endmodule

// File: tb/tb_output_pingpong_buffer.sv
// tb_output_pingpong_buffer
//   Scoreboard bench for output_pingpong_buffer. A reference model of the two
//   banks (contents, FULL flags, fill/drain pointers) is updated from the
//   stimulus; every accepted commit pushes the whole bank, in row-major order,
//   into an expected-word queue that a monitor pops on each output handshake.
//   Define OUTBUF_ACCUM_EN for both files to exercise the accumulate path.
module tb_output_pingpong_buffer;
  localparam int DW   = 16;
  localparam int NC   = 4;
  localparam int ROWS = 4;
  localparam int RW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_pingpong_buffer_if #(.DATA_WIDTH(DW), .NUM_CH(NC), .ROW_W(RW)) bus ();

  output_pingpong_buffer #(.DATA_WIDTH(DW), .NUM_CH(NC), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [DW-1:0] d; logic last; } exp_t;
  exp_t            q[$];
  logic [DW-1:0]   m_mem [2][ROWS][NC];
  logic [1:0]      m_full = '0;
  bit              m_wbank = 0;
  bit              m_rbank = 0;
  int              hs_in_bank = 0;
  bit              stall_pend = 0;
  logic [DW-1:0]   stall_data;
  logic            stall_last;
  bit              ready_now;
  logic [DW-1:0]   mw;
  int              sum;
  exp_t            e;

  // Observe at negedge: inputs are stable and describe what the next edge does.
  always @(negedge clk) begin
    if (rst) begin
      m_full = '0; m_wbank = 0; m_rbank = 0;
      q.delete(); stall_pend = 0; hs_in_bank = 0;
    end else begin
      check("wr_ready", 32'(bus.wr_ready), 32'(!m_full[m_wbank]));
      check("bank_full", 32'(bus.bank_full), 32'(m_full));
      if (stall_pend) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(bus.out_data), 32'(stall_data));
        check("hold_last", 32'(bus.out_last), 32'(stall_last));
      end
      stall_pend = bus.out_valid && !bus.out_ready;
      stall_data = bus.out_data;
      stall_last = bus.out_last;

      ready_now = !m_full[m_wbank];
      if (bus.wr_en && ready_now && int'(bus.wr_row) < ROWS) begin
        for (int l = 0; l < NC; l++) begin
          if (bus.wr_mask[l]) begin
            mw = bus.wr_data[l*DW +: DW];
`ifdef OUTBUF_ACCUM_EN
            if (bus.wr_acc) begin
              sum = int'($signed(m_mem[m_wbank][bus.wr_row][l])) + int'($signed(mw));
              if (sum > 32767) sum = 32767;
              if (sum < -32768) sum = -32768;
              mw = DW'(sum);
            end
`endif
            m_mem[m_wbank][bus.wr_row][l] = mw;
          end
        end
      end
      if (bus.wr_commit && ready_now) begin
        for (int r = 0; r < ROWS; r++)
          for (int l = 0; l < NC; l++)
            q.push_back('{d: m_mem[m_wbank][r][l], last: (r == ROWS-1 && l == NC-1)});
        m_full[m_wbank] = 1'b1;
        m_wbank = !m_wbank;
      end

      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_word actual=%0h required=none at %0t", bus.out_data, $time);
        end else begin
          e = q.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e.d));
          check("out_last", 32'(bus.out_last), 32'(e.last));
          hs_in_bank++;
          if (e.last) begin
            m_full[m_rbank] = 1'b0;
            m_rbank = !m_rbank;
            hs_in_bank = 0;
          end
        end
      end
    end
  end

  // ---------------- out_ready driver ----------------
  int         rdy_mode = 0;        // 0 always 1, 1 always 0, 2 random, 3 pattern
  logic [3:0] rdy_pat  = 4'b1001;  // applied LSB first: 1,0,0,1,...
  int         pat_i    = 0;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'b0;
        2: bus.out_ready = 1'($urandom_range(0, 1));
        default: begin bus.out_ready = rdy_pat[pat_i % 4]; pat_i++; end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_row(input int row, input logic [NC-1:0] mask,
                           input logic [NC*DW-1:0] data, input bit commit);
    bus.wr_en = 1'b1; bus.wr_row = RW'(row); bus.wr_mask = mask;
    bus.wr_data = data; bus.wr_commit = commit;
`ifdef OUTBUF_ACCUM_EN
    bus.wr_acc = 1'b0;
`endif
    tick();
    bus.wr_en = 1'b0; bus.wr_commit = 1'b0;
  endtask

  function automatic logic [NC*DW-1:0] rand_row();
    logic [NC*DW-1:0] v;
    for (int l = 0; l < NC; l++) v[l*DW +: DW] = DW'($urandom);
    return v;
  endfunction

  // Fill all rows with random data; optionally commit alongside the last row.
  task automatic fill_tile(input bit commit_with_last);
    for (int r = 0; r < ROWS; r++)
      write_row(r, '1, rand_row(), commit_with_last && (r == ROWS-1));
  endtask

  task automatic commit_only();
    bus.wr_commit = 1'b1; tick(); bus.wr_commit = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400 && (q.size() != 0 || m_full != 2'b00); k++) tick();
    check("drain_timeout", 32'(q.size()), 32'd0);
    tick(); tick();
  endtask

  logic [NC*DW-1:0] rowv;

  initial begin
    bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_mask = '0; bus.wr_data = '0;
    bus.wr_commit = 1'b0;
`ifdef OUTBUF_ACCUM_EN
    bus.wr_acc = 1'b0;
`endif
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    check("rst_ready", 32'(bus.wr_ready), 32'd1);

    // Tile of row*10+lane, commit latency check, full-rate drain.
    rdy_mode = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int l = 0; l < NC; l++) rowv[l*DW +: DW] = DW'(r*10 + l);
      write_row(r, '1, rowv, 1'b0);
    end
    bus.wr_commit = 1'b1;
    tick();
    bus.wr_commit = 1'b0;
    check("lat_full", 32'(bus.bank_full), 32'd1);
    check("lat_valid_e", 32'(bus.out_valid), 32'd0);
    tick();
    check("lat_valid_e1", 32'(bus.out_valid), 32'd1);
    check("lat_word0", 32'(bus.out_data), 32'd0);
    wait_drain();

    // Both banks full under back-pressure; extra writes/commit are ignored.
    rdy_mode = 1;
    fill_tile(1'b1);
    fill_tile(1'b0);
    commit_only();
    check("both_full_ready", 32'(bus.wr_ready), 32'd0);
    write_row(0, '1, {NC{16'hDEAD}}, 1'b1);
    write_row(1, '1, {NC{16'hBEEF}}, 1'b0);
    repeat (3) tick();
    rdy_mode = 0;
    wait_drain();

    // Stall pattern during a drain.
    rdy_mode = 3;
    fill_tile(1'b1);
    wait_drain();

    // Masked write over a row of 9s.
    rdy_mode = 0;
    write_row(0, '1, {NC{16'd9}}, 1'b0);
    write_row(0, 4'b0101, rand_row(), 1'b0);
    for (int r = 1; r < ROWS; r++) write_row(r, '1, rand_row(), r == ROWS-1);
    wait_drain();

    // Reset while word 5 is presented.
    fill_tile(1'b1);
    for (int k = 0; k < 100 && hs_in_bank != 5; k++) tick();
    check("reach_word5", 32'(hs_in_bank), 32'd5);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data", 32'(bus.out_data), 32'd0);
    check("mid_rst_full", 32'(bus.bank_full), 32'd0);
    check("mid_rst_ready", 32'(bus.wr_ready), 32'd1);
    rst = 1'b0;
    fill_tile(1'b1);
    wait_drain();

`ifdef OUTBUF_ACCUM_EN
    // Saturating accumulate: 7FF0+0020 clamps to 7FFF, -5+3 gives -2.
    write_row(0, 4'b0011, {32'h0, 16'hFFFB, 16'h7FF0}, 1'b0);
    bus.wr_en = 1'b1; bus.wr_row = '0; bus.wr_mask = 4'b0011;
    bus.wr_data = {32'h0, 16'h0003, 16'h0020}; bus.wr_acc = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.wr_acc = 1'b0;
    for (int r = 1; r < ROWS; r++) write_row(r, '1, rand_row(), r == ROWS-1);
    wait_drain();
`endif

    // Random traffic with random back-pressure.
    rdy_mode = 2;
    for (int c = 0; c < 400; c++) begin
      bus.wr_en     = ($urandom_range(0, 3) != 0);
      bus.wr_row    = RW'($urandom_range(0, ROWS-1));
      bus.wr_mask   = NC'($urandom);
      bus.wr_data   = rand_row();
      bus.wr_commit = ($urandom_range(0, 11) == 0);
`ifdef OUTBUF_ACCUM_EN
      bus.wr_acc    = 1'($urandom_range(0, 1));
`endif
      tick();
    end
    bus.wr_en = 1'b0; bus.wr_commit = 1'b0;
    rdy_mode = 0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/output_pingpong_buffer.md
# output_pingpong_buffer

Double-banked result buffer between the systolic array and the external output interface. Each cycle it accepts one row of NUM_CH column results (one per PE column), collects ROWS rows into a bank, and on commit streams the bank out one word per cycle over a valid/ready port. Because there are two banks, the array can fill the next tile while the previous one drains. It replaces the single-port, externally addressed output SRAM with built-in read-out sequencing and back-pressure.

## Interface
- DATA_WIDTH, 16: bits per stored result.
- NUM_CH, 4: results per written row (array columns).
- ROWS, 4: rows per bank; bank holds ROWS*NUM_CH words.
- ROW_W, $clog2(ROWS): row address width (derived, min 1).
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write one row this cycle.
- wr_row  in  ROW_W  row address within the current fill bank.
- wr_mask  in  NUM_CH  per-lane write enable; bit i gates lane i.
- wr_data  in  NUM_CH*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_acc  in  1  accumulate instead of overwrite (present only with OUTBUF_ACCUM_EN).
- wr_commit  in  1  close the fill bank and hand it to the drain side.
- wr_ready  out  1  a fill bank is available; writes and commits are accepted only when 1.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_data  out  DATA_WIDTH  streamed result word (registered).
- out_last  out  1  marks the final word of a bank.
- bank_full  out  2  per-bank FULL status, for debug and control.

## Operation
- Each bank has state FREE or FULL. There is a fill pointer wbank and a drain pointer rbank.
- wr_ready = (state[wbank] == FREE), combinational from registered state.
- Write: when wr_en && wr_ready, each lane i with wr_mask[i]=1 stores to bank wbank at [wr_row][i]. Masked lanes keep their old contents.
- wr_row >= ROWS: the write is dropped.
- wr_en or wr_commit while wr_ready=0: ignored, no state change.
- Commit: when wr_commit && wr_ready, state[wbank] becomes FULL and wbank toggles.
- wr_en and wr_commit in the same cycle: the write lands in the bank being committed.
- Drain FSM states and transitions:
  - IDLE -> STREAM when state[rbank] == FULL. On that edge it loads word 0 into out_data and asserts out_valid.
  - STREAM advances on each handshake, loading the next word at the same edge (full throughput).
  - Read order is row-major: row 0 lanes 0..NUM_CH-1, then row 1, and so on.
  - out_last=1 with word index ROWS*NUM_CH-1.
  - Handshake on the last word: state[rbank] becomes FREE, rbank toggles, out_valid drops, FSM returns to IDLE.
- out_data and out_last must stay stable while out_valid && !out_ready.
- Simultaneous commit and final drain handshake: both take effect at the same edge. wr_ready is re-evaluated from the new state.
- Memory contents are not reset. Only control state is reset.
- Reset values (also for reset mid-operation): bank states FREE; wbank=rbank=0; FSM IDLE; word counter 0; out_valid=0; out_data=0; out_last=0; bank_full=2'b00; wr_ready=1 in the cycle after reset. Any drain in progress is abandoned with no further words.

## Timing
- Write to storage: 1 edge.
- Commit sampled at edge E: bank_full set after E. First word is valid after E+1 (out_valid high 2 cycles after commit is presented).
- Drain: one word per cycle while out_ready=1. A bank drains in ROWS*NUM_CH cycles, plus at least one idle cycle between banks.
- Bank reuse: the drained bank is FREE after its last-word handshake edge. wr_ready rises in the next cycle.

## Configuration
- OUTBUF_ACCUM_EN defined:
  - Port wr_acc exists.
  - An accepted write with wr_acc=1 stores, per enabled lane, the signed saturating sum of old contents and wr_data (clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]).
  - wr_acc=0 overwrites.
- OUTBUF_ACCUM_EN undefined: no wr_acc port; accepted writes always overwrite.

## Test plan
- Reset, then write rows 0..3 with lane values row*10+lane, commit -> out_valid 2 cycles later; 16 words 0,1,2,3,10,...,33 with out_ready=1; out_last only on 33.
- Fill and commit bank 0 with out_ready=0, fill and commit bank 1 -> wr_ready=0 and further writes ignored; raise out_ready -> bank 0 drains, then wr_ready=1, then bank 1 drains.
- Toggle out_ready 1,0,0,1,... during a drain -> out_data is held while stalled; no word is lost or duplicated.
- Assert rst mid-drain at word 5 -> next cycle out_valid=0, out_data=0, bank_full=00, wr_ready=1; a new tile then drains from word 0.
- With OUTBUF_ACCUM_EN: write 16'h7FF0, then wr_acc with 16'h0020 on lane 0, and -5 then wr_acc +3 on lane 1 -> outputs 16'h7FFF and -2.
- Write with wr_mask=4'b0101 over a full row of 9s -> lanes 0 and 2 take new data; lanes 1 and 3 read 9.
